// File: rtl/data_block_memory.sv
// Block-wide backing memory behind the data cache: 128-bit block reads/writes
// with a fixed LATENCY-cycle service time signalled through mem_busywait.
module data_block_memory #(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = 5,
  parameter int BLOCK_W   = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [27:0]        mem_address,
  input  logic [BLOCK_W-1:0] mem_writedata,
  output logic [BLOCK_W-1:0] mem_readdata,
  output logic               mem_busywait
);

  localparam int NUM_BLOCKS = 2 ** ADDR_BITS;
  localparam int CNT_W      = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic                 r_op_write;
  logic [ADDR_BITS-1:0] r_idx;
  logic [BLOCK_W-1:0]   r_data;
  logic [BLOCK_W-1:0]   r_readdata;
  logic [BLOCK_W-1:0]   r_mem [NUM_BLOCKS];

  logic w_req;
  logic w_unused_addr;

  // Exactly one strobe is a request; both high together is ignored.
  assign w_req         = mem_read ^ mem_write;
  // Upper address bits only alias onto the stored blocks.
  assign w_unused_addr = ^mem_address[27:ADDR_BITS];

  assign mem_busywait = ((r_state == IDLE) && w_req) || (r_state == BUSY);
  assign mem_readdata = r_readdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_data     <= '0;
      r_readdata <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op_write <= mem_write;
            r_idx      <= mem_address[ADDR_BITS-1:0];
            r_data     <= mem_writedata;
            r_count    <= CNT_W'(1);
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          // Latched op/index/data are used; live inputs are ignored while busy.
          if (r_count == LAT_C) begin
            if (r_op_write) r_mem[r_idx] <= r_data;
            else            r_readdata   <= r_mem[r_idx];
            r_count <= '0;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_block_memory.sv
// Self-checking bench: timestamp-based transaction model compared every cycle,
// directed literal scenarios, then randomized strobe/address/data traffic.
module tb_data_block_memory;
  localparam int LAT = 5;
  localparam int NB  = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [27:0]  mem_address = '0;
  logic [127:0] mem_writedata = '0;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  always #5 clock = ~clock;

  data_block_memory #(.ADDR_BITS(6), .LATENCY(LAT), .BLOCK_W(128)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  int checks = 0;
  int fails  = 0;
  bit run    = 0;

  // Reference model: an active transaction finishes at a fixed cycle stamp.
  logic [127:0] m_mem [NB];
  logic [127:0] m_rd;
  logic [127:0] m_data;
  bit           m_act;
  bit           m_wr;
  int           m_idx;
  longint       cyc = 0;
  longint       m_done = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_rd  = '0;
      m_act = 0;
    end else begin
      cyc++;
      if (m_act) begin
        if (cyc == m_done) begin
          if (m_wr) m_mem[m_idx] = m_data;
          else      m_rd = m_mem[m_idx];
          m_act = 0;
        end
      end else if (mem_read ^ mem_write) begin
        m_act  = 1;
        m_wr   = mem_write;
        m_idx  = int'(mem_address[5:0]);
        m_data = mem_writedata;
        m_done = cyc + LAT;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (run) begin
      chk("model_busywait", {127'b0, mem_busywait}, {127'b0, (m_act || (mem_read ^ mem_write))});
      chk("model_readdata", mem_readdata, m_rd);
    end
  end

  task automatic drive(input bit r, input bit w, input logic [27:0] a, input logic [127:0] d);
    @(posedge clock);
    #1;
    mem_read      = r;
    mem_write     = w;
    mem_address   = a;
    mem_writedata = d;
  endtask

  // One transaction: strobe for one edge, then scramble inputs and count busy cycles.
  task automatic op(input bit w, input logic [27:0] a, input logic [127:0] d, output int n);
    drive(!w, w, a, d);
    drive(0, 0, 28'($urandom), {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (!mem_busywait) break;
      n++;
    end
  endtask

  localparam logic [127:0] D1 = 128'hDEADBEEF_0BADF00D_C0FFEE00_00000123;
  localparam logic [127:0] DA = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [127:0] DB = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    run = 1;
    @(negedge clock);
    chk("reset_busywait", {127'b0, mem_busywait}, 128'h0);
    chk("reset_readdata", mem_readdata, 128'h0);
    op(0, 28'h5, '0, n);
    chk("reset_read_blk5", mem_readdata, 128'h0);

    op(1, 28'h3, D1, n);
    chk("write_latency", 128'(n), 128'(LAT));
    op(0, 28'h3, '0, n);
    chk("read_latency", 128'(n), 128'(LAT));
    chk("read_back_3", mem_readdata, D1);

    // Address/data changed mid-busy (inside op) must not redirect the access.
    op(1, 28'hA, DB, n);
    op(0, 28'hB, '0, n);
    chk("mid_busy_neighbor", mem_readdata, 128'h0);
    op(0, 28'hA, '0, n);
    chk("mid_busy_orig", mem_readdata, DB);

    op(1, 28'h41, DA, n);
    op(0, 28'h1, '0, n);
    chk("alias_read", mem_readdata, DA);

    // Both strobes high: no transaction, nothing changes.
    drive(1, 1, 28'h3, DA);
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (mem_busywait) n++;
    end
    drive(0, 0, '0, '0);
    chk("both_high_busy", 128'(n), 128'h0);
    chk("both_high_rdata", mem_readdata, DA);
    op(0, 28'h3, '0, n);
    chk("both_high_storage", mem_readdata, D1);

    // Reset with the write pending at count 3.
    drive(0, 1, 28'h7, DB);
    drive(0, 0, '0, '0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    chk("abort_busywait", {127'b0, mem_busywait}, 128'h0);
    chk("abort_readdata", mem_readdata, 128'h0);
    @(posedge clock);
    #1 reset = 0;
    op(0, 28'h7, '0, n);
    chk("abort_no_write", mem_readdata, 128'h0);

    // Back-to-back reads with the strobe held through the first completion.
    op(1, 28'h9, DB, n);
    drive(1, 0, 28'h9, '0);
    n = 0;
    repeat (LAT + 2) begin
      @(negedge clock);
      if (mem_busywait) n++;
    end
    drive(0, 0, '0, '0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (!mem_busywait) break;
      n++;
    end
    chk("b2b_busy_cycles", 128'(n), 128'(2 * LAT + 2));
    chk("b2b_readdata", mem_readdata, DB);

    // Random traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      @(posedge clock);
      #1;
      if ($urandom_range(0, 399) == 0) reset = 1;
      else reset = 0;
      mem_read      = (r < 3) || (r == 6);
      mem_write     = (r >= 3 && r < 7);
      mem_address   = 28'($urandom_range(0, 127));
      mem_writedata = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clock);
    #1;
    reset = 0;
    mem_read = 0;
    mem_write = 0;
    repeat (2 * LAT + 4) @(posedge clock);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
